// File: rtl/spi_ram_pkg.sv
// Shared opcodes, frame geometry and FSM/grant types for the SPI RAM sequencer.
package spi_ram_pkg;

    localparam logic [7:0] OP_READ    = 8'h03;
    localparam logic [7:0] OP_WRITE   = 8'h02;
    localparam int         FRAME_BITS = 48;
    localparam int         DATA_BITS  = 16;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic       {GNT_I, GNT_D}      grant_t;

    // Words travel low byte first on the wire, each byte MSB first.
    function automatic logic [DATA_BITS-1:0] swap_bytes(input logic [DATA_BITS-1:0] w);
        return {w[7:0], w[15:8]};
    endfunction

endpackage

// File: rtl/spi_frame_shifter.sv
// 48-bit SPI mode-0 frame engine: loads a frame, toggles spi_clk at clk/2,
// shifts MOSI on falling phases and captures MISO on rising phases.
module spi_frame_shifter
    import spi_ram_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [FRAME_BITS-1:0] frame,
    input  logic                  spi_miso,
    output logic                  spi_clk,
    output logic                  spi_mosi,
    output logic                  last_phase,
    output logic [DATA_BITS-1:0]  rx_data
);

    localparam int               CNT_W    = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    logic [FRAME_BITS-1:0] shift_q;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  active;
    logic                  phase;

    // NOTE: the shift register is a handful of flops, not a memory, so it is
    // reset like any other state; that also guarantees MOSI reads 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            bit_cnt <= '0;
            active  <= 1'b0;
            phase   <= 1'b0;
            rx_data <= '0;
        end else if (load) begin
            shift_q <= frame;
            bit_cnt <= '0;
            active  <= 1'b1;
            phase   <= 1'b0;
        end else if (active) begin
            if (!phase) begin
                phase   <= 1'b1;
                rx_data <= {rx_data[DATA_BITS-2:0], spi_miso};
            end else begin
                phase   <= 1'b0;
                shift_q <= {shift_q[FRAME_BITS-2:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
                if (bit_cnt == LAST_BIT)
                    active <= 1'b0;
            end
        end
    end

    // A completed frame has shifted in 48 zeros, so MOSI idles low between frames.
    assign spi_clk    = phase;
    assign spi_mosi   = shift_q[FRAME_BITS-1];
    assign last_phase = active && phase && (bit_cnt == LAST_BIT);

endmodule

// File: rtl/spi_ram_arbiter.sv
// Round-robin arbiter between instruction fetch and data port, sequencing one
// 16-bit SPI RAM read or write per grant.
module spi_ram_arbiter
    import spi_ram_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              spi_clk,
    output logic              spi_mosi,
    output logic              spi_select,
    input  logic              spi_miso
);

    state_t                state;
    grant_t                last_grant;
    logic                  is_write;
    logic                  gnt_d;
    logic                  wr_sel;
    logic                  load;
    logic [23:0]           byte_addr;
    logic [FRAME_BITS-1:0] frame;
    logic                  last_phase;
    logic [DATA_BITS-1:0]  rx_data;

    // NOTE: every always_comb output is assigned on every path, so no latch forms.
    always_comb begin
        gnt_d     = d_req && (!i_req || last_grant == GNT_I);
        wr_sel    = gnt_d && d_we;
        load      = (state == IDLE) && (i_req || d_req);
        byte_addr = gnt_d ? 24'({d_addr, 1'b0}) : 24'({i_addr, 1'b0});
        frame     = {wr_sel ? OP_WRITE : OP_READ, byte_addr,
                     wr_sel ? swap_bytes(d_wdata) : {DATA_BITS{1'b0}}};
    end

    spi_frame_shifter u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .frame      (frame),
        .spi_miso   (spi_miso),
        .spi_clk    (spi_clk),
        .spi_mosi   (spi_mosi),
        .last_phase (last_phase),
        .rx_data    (rx_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= GNT_I;
            is_write   <= 1'b0;
            spi_select <= 1'b1;
            busy       <= 1'b0;
            i_done     <= 1'b0;
            d_done     <= 1'b0;
            rdata      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        state      <= SHIFT;
                        last_grant <= gnt_d ? GNT_D : GNT_I;
                        is_write   <= wr_sel;
                        spi_select <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (last_phase) begin
                        state      <= DONE;
                        spi_select <= 1'b1;
                        if (last_grant == GNT_D)
                            d_done <= 1'b1;
                        else
                            i_done <= 1'b1;
                        if (!is_write)
                            rdata <= swap_bytes(rx_data);
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    i_done <= 1'b0;
                    d_done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
